// File: rtl/stroke_pkg.sv
// Shared definitions for the stroke-ratio scheduler: phase encodings,
// division handshake states and the default datapath width.
package stroke_pkg;

    localparam int DEF_W = 32;

    typedef enum logic [1:0] {
        PH_WAIT  = 2'd0,
        PH_DRIVE = 2'd1,
        PH_RECOV = 2'd2
    } phase_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_WAIT = 1'b1
    } div_state_t;

endpackage

// File: rtl/stroke_ratio_sched_phase_counter.sv
// Edge detection, drive/recovery phase tracking with saturating per-phase
// counters and a stall timer; flags each completed stroke with its counts.
module phase_counter
    import stroke_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int STALL_MAX = 1048575
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_start_drive,
    input  logic         i_start_recovery,
    output logic         o_stroke_done,
    output logic [W-1:0] o_snap_rec,
    output logic [W-1:0] o_snap_drv,
    output phase_t       o_phase
);

    localparam int STW = $clog2(STALL_MAX + 1);

    logic           r_sd_q;
    logic           r_sr_q;
    logic           r_de;
    logic           r_re;
    phase_t         r_phase;
    logic [W-1:0]   r_drv_cnt;
    logic [W-1:0]   r_rec_cnt;
    logic [STW-1:0] r_stall;

    logic           w_de;
    logic           w_re;
    logic           w_stall_hit;
    logic [W-1:0]   w_drv_inc;
    logic [W-1:0]   w_rec_inc;

    // Simultaneous edges cancel each other; the phase simply keeps counting.
    assign w_de        = r_de & ~r_re;
    assign w_re        = r_re & ~r_de;
    assign w_stall_hit = (r_stall == STW'(STALL_MAX - 1));
    assign w_drv_inc   = (r_drv_cnt == '1) ? r_drv_cnt : r_drv_cnt + W'(1);
    assign w_rec_inc   = (r_rec_cnt == '1) ? r_rec_cnt : r_rec_cnt + W'(1);

    assign o_stroke_done = (r_phase == PH_RECOV) && w_de;
    assign o_snap_rec    = r_rec_cnt;
    assign o_snap_drv    = r_drv_cnt;
    assign o_phase       = r_phase;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sd_q    <= 1'b0;
            r_sr_q    <= 1'b0;
            r_de      <= 1'b0;
            r_re      <= 1'b0;
            r_phase   <= PH_WAIT;
            r_drv_cnt <= '0;
            r_rec_cnt <= '0;
            r_stall   <= '0;
        end else begin
            r_sd_q <= i_start_drive;
            r_sr_q <= i_start_recovery;
            r_de   <= i_start_drive & ~r_sd_q;
            r_re   <= i_start_recovery & ~r_sr_q;

            unique case (r_phase)
                PH_WAIT: begin
                    if (w_de) begin
                        r_phase   <= PH_DRIVE;
                        r_drv_cnt <= W'(1);
                        r_rec_cnt <= '0;
                        r_stall   <= '0;
                    end
                end
                PH_DRIVE: begin
                    if (w_de) begin
                        r_drv_cnt <= W'(1);
                        r_stall   <= '0;
                    end else if (w_re) begin
                        r_phase   <= PH_RECOV;
                        r_rec_cnt <= W'(1);
                        r_stall   <= '0;
                    end else if (w_stall_hit) begin
                        r_phase   <= PH_WAIT;
                        r_drv_cnt <= '0;
                        r_rec_cnt <= '0;
                        r_stall   <= '0;
                    end else begin
                        r_drv_cnt <= w_drv_inc;
                        r_stall   <= r_stall + STW'(1);
                    end
                end
                PH_RECOV: begin
                    // A drive edge here closes the stroke and opens the next one.
                    if (w_de) begin
                        r_phase   <= PH_DRIVE;
                        r_drv_cnt <= W'(1);
                        r_rec_cnt <= '0;
                        r_stall   <= '0;
                    end else if (w_stall_hit) begin
                        r_phase   <= PH_WAIT;
                        r_drv_cnt <= '0;
                        r_rec_cnt <= '0;
                        r_stall   <= '0;
                    end else begin
                        r_rec_cnt <= w_rec_inc;
                        r_stall   <= r_stall + STW'(1);
                    end
                end
                default: begin
                    r_phase   <= PH_WAIT;
                    r_drv_cnt <= '0;
                    r_rec_cnt <= '0;
                    r_stall   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stroke_ratio_sched.sv
// Stroke-ratio scheduler: launches one recovery/drive division per completed
// stroke on the shared divider and latches the resulting ratio.
module stroke_ratio_sched
    import stroke_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int DIV_TMO   = 64,
    parameter int STALL_MAX = 1048575,
    parameter int SC_W      = 16
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            start_drive,
    input  logic            start_recovery,
    output logic            div_start,
    output logic [W-1:0]    div_num,
    output logic [W-1:0]    div_den,
    input  logic            div_done,
    input  logic [W-1:0]    div_result,
    output logic [W-1:0]    ratio,
    output logic            ratio_valid,
    output logic [SC_W-1:0] stroke_count,
    output logic [1:0]      phase,
    output logic            overrun,
    output logic            div_tmo
);

    localparam int TW = $clog2(DIV_TMO + 1);

    logic            w_stroke_done;
    logic [W-1:0]    w_snap_rec;
    logic [W-1:0]    w_snap_drv;
    phase_t          w_phase;

    div_state_t      r_dstate;
    logic [TW-1:0]   r_tmo;
    logic            r_div_start;
    logic [W-1:0]    r_div_num;
    logic [W-1:0]    r_div_den;
    logic [W-1:0]    r_ratio;
    logic            r_ratio_valid;
    logic [SC_W-1:0] r_stroke_count;
    logic            r_overrun;
    logic            r_div_tmo;

    phase_counter #(
        .W         (W),
        .STALL_MAX (STALL_MAX)
    ) u_phase_counter (
        .clk              (clk),
        .clr_n            (clr_n),
        .i_start_drive    (start_drive),
        .i_start_recovery (start_recovery),
        .o_stroke_done    (w_stroke_done),
        .o_snap_rec       (w_snap_rec),
        .o_snap_drv       (w_snap_drv),
        .o_phase          (w_phase)
    );

    // Operands stay registered for the whole operation, so the divider may
    // sample them any time before it signals done.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_dstate       <= D_IDLE;
            r_tmo          <= '0;
            r_div_start    <= 1'b0;
            r_div_num      <= '0;
            r_div_den      <= '0;
            r_ratio        <= '0;
            r_ratio_valid  <= 1'b0;
            r_stroke_count <= '0;
            r_overrun      <= 1'b0;
            r_div_tmo      <= 1'b0;
        end else begin
            r_div_start   <= 1'b0;
            r_ratio_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_div_tmo     <= 1'b0;

            unique case (r_dstate)
                D_IDLE: begin
                    if (w_stroke_done && (w_snap_rec != '0) && (w_snap_drv != '0)) begin
                        r_div_num   <= w_snap_rec;
                        r_div_den   <= w_snap_drv;
                        r_div_start <= 1'b1;
                        r_tmo       <= '0;
                        r_dstate    <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    // Strokes finishing while busy are dropped; the running op is untouched.
                    if (w_stroke_done) begin
                        r_overrun <= 1'b1;
                    end
                    if (div_done) begin
                        r_ratio        <= div_result;
                        r_stroke_count <= r_stroke_count + SC_W'(1);
                        r_ratio_valid  <= 1'b1;
                        r_dstate       <= D_IDLE;
                    end else if (r_tmo == TW'(DIV_TMO - 1)) begin
                        r_div_tmo <= 1'b1;
                        r_dstate  <= D_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: r_dstate <= D_IDLE;
            endcase
        end
    end

    assign div_start    = r_div_start;
    assign div_num      = r_div_num;
    assign div_den      = r_div_den;
    assign ratio        = r_ratio;
    assign ratio_valid  = r_ratio_valid;
    assign stroke_count = r_stroke_count;
    assign phase        = w_phase;
    assign overrun      = r_overrun;
    assign div_tmo      = r_div_tmo;

endmodule

// File: tb/tb_stroke_ratio_sched.sv
// Directed bench for stroke_ratio_sched with a behavioural divider and a
// scoreboard of expected divider operands and ratios.
module tb_stroke_ratio_sched;

    localparam int W       = 32;
    localparam int DIV_TMO = 64;
    localparam int SC_W    = 16;

    typedef struct {
        logic [W-1:0] num;
        logic [W-1:0] den;
    } op_t;

    logic            clk;
    logic            clr_n;
    logic            start_drive;
    logic            start_recovery;
    logic            div_start;
    logic [W-1:0]    div_num;
    logic [W-1:0]    div_den;
    logic            div_done;
    logic [W-1:0]    div_result;
    logic [W-1:0]    ratio;
    logic            ratio_valid;
    logic [SC_W-1:0] stroke_count;
    logic [1:0]      phase;
    logic            overrun;
    logic            div_tmo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nStart, nValid, nOverrun, nTmo;
    int startCyc, tmoCyc, riseCyc;

    op_t          opQ[$];
    logic [W-1:0] ratioQ[$];

    int           divDelay = 5;
    logic [W-1:0] divRes = '0;
    bit           divHang = 0;
    int           divCnt = 0;

    stroke_ratio_sched #(
        .W         (W),
        .DIV_TMO   (DIV_TMO),
        .STALL_MAX (100),
        .SC_W      (SC_W)
    ) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .start_drive    (start_drive),
        .start_recovery (start_recovery),
        .div_start      (div_start),
        .div_num        (div_num),
        .div_den        (div_den),
        .div_done       (div_done),
        .div_result     (div_result),
        .ratio          (ratio),
        .ratio_valid    (ratio_valid),
        .stroke_count   (stroke_count),
        .phase          (phase),
        .overrun        (overrun),
        .div_tmo        (div_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Behavioural divider: answers divDelay cycles after seeing div_start.
    always @(negedge clk) begin
        div_done = 1'b0;
        if (!clr_n) begin
            divCnt = 0;
        end else begin
            if (divCnt > 0) begin
                divCnt--;
                if (divCnt == 0) begin
                    div_done   = 1'b1;
                    div_result = divRes;
                end
            end
            if (div_start && !divHang) divCnt = divDelay;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (clr_n) begin
            if (div_start) begin
                nStart++;
                startCyc = cyc;
                if (opQ.size() == 0) begin
                    checkOutput("unexpected_div_start", 1, 0);
                end else begin
                    op_t e;
                    e = opQ.pop_front();
                    checkOutput("div_num", div_num, e.num);
                    checkOutput("div_den", div_den, e.den);
                end
            end
            if (ratio_valid) begin
                nValid++;
                if (ratioQ.size() == 0) begin
                    checkOutput("unexpected_ratio_valid", 1, 0);
                end else begin
                    checkOutput("ratio", ratio, ratioQ.pop_front());
                end
            end
            if (overrun) nOverrun++;
            if (div_tmo) begin
                nTmo++;
                tmoCyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit drv, input bit rec);
        start_drive    = drv;
        start_recovery = rec;
    endtask

    task automatic clearCounts();
        nStart = 0; nValid = 0; nOverrun = 0; nTmo = 0;
        startCyc = 0; tmoCyc = 0;
    endtask

    task automatic doReset();
        clr_n = 1'b0;
        applyStimulus(0, 0);
        tick(2);
        clr_n = 1'b1;
        tick(2);
        clearCounts();
    endtask

    function automatic op_t mkOp(input int num, input int den);
        op_t o;
        o.num = W'(num);
        o.den = W'(den);
        return o;
    endfunction

    initial begin
        clr_n = 1'b0;
        applyStimulus(0, 0);
        div_done   = 1'b0;
        div_result = '0;
        clearCounts();
        tick(3);
        checkOutput("reset_phase", W'(phase), 0);
        checkOutput("reset_ratio", ratio, 0);
        doReset();

        $display("[TB] basic stroke 10/25");
        divDelay = 5; divRes = 2;
        applyStimulus(1, 0); tick(10);
        applyStimulus(0, 1); tick(25);
        opQ.push_back(mkOp(25, 10));
        ratioQ.push_back(2);
        applyStimulus(1, 0);
        riseCyc = cyc;
        tick(12);
        checkOutput("basic_n_start", W'(nStart), 1);
        checkOutput("basic_latency", W'(startCyc - riseCyc), 2);
        checkOutput("basic_n_valid", W'(nValid), 1);
        checkOutput("basic_ratio", ratio, 2);
        checkOutput("basic_count", W'(stroke_count), 1);
        checkOutput("basic_overrun", W'(nOverrun), 0);

        $display("[TB] reset during division");
        applyStimulus(0, 1); tick(5);
        divHang = 1;
        opQ.push_back(mkOp(5, 12));
        applyStimulus(1, 0); tick(4);
        checkOutput("rst_n_start", W'(nStart), 2);
        clr_n = 1'b0;
        applyStimulus(0, 0);
        #2;
        checkOutput("rst_phase", W'(phase), 0);
        checkOutput("rst_div_start", W'(div_start), 0);
        checkOutput("rst_div_num", div_num, 0);
        checkOutput("rst_div_den", div_den, 0);
        checkOutput("rst_ratio", ratio, 0);
        checkOutput("rst_ratio_valid", W'(ratio_valid), 0);
        checkOutput("rst_count", W'(stroke_count), 0);
        checkOutput("rst_overrun", W'(overrun), 0);
        checkOutput("rst_div_tmo", W'(div_tmo), 0);
        tick(2);
        clr_n = 1'b1;
        divHang = 0;
        tick(2);
        checkOutput("rst_release_phase", W'(phase), 0);
        applyStimulus(1, 0); tick(3);
        checkOutput("rst_de_phase", W'(phase), 1);

        $display("[TB] overrun");
        doReset();
        divDelay = 40; divRes = 3;
        applyStimulus(1, 0); tick(10);
        applyStimulus(0, 1); tick(30);
        opQ.push_back(mkOp(30, 10));
        ratioQ.push_back(3);
        applyStimulus(1, 0); tick(5);
        applyStimulus(0, 1); tick(15);
        applyStimulus(1, 0); tick(30);
        checkOutput("ovr_n_overrun", W'(nOverrun), 1);
        checkOutput("ovr_n_start", W'(nStart), 1);
        checkOutput("ovr_n_valid", W'(nValid), 1);
        checkOutput("ovr_count", W'(stroke_count), 1);
        checkOutput("ovr_ratio", ratio, 3);

        $display("[TB] divider timeout");
        doReset();
        divHang = 1;
        applyStimulus(1, 0); tick(8);
        applyStimulus(0, 1); tick(24);
        opQ.push_back(mkOp(24, 8));
        applyStimulus(1, 0); tick(6);
        applyStimulus(0, 1); tick(80);
        checkOutput("tmo_n_tmo", W'(nTmo), 1);
        checkOutput("tmo_latency", W'(tmoCyc - startCyc), DIV_TMO);
        checkOutput("tmo_ratio", ratio, 0);
        checkOutput("tmo_n_valid", W'(nValid), 0);
        divHang = 0; divDelay = 3; divRes = 7;
        opQ.push_back(mkOp(80, 6));
        ratioQ.push_back(7);
        applyStimulus(1, 0); tick(10);
        checkOutput("tmo_next_n_start", W'(nStart), 2);
        checkOutput("tmo_next_ratio", ratio, 7);
        checkOutput("tmo_next_count", W'(stroke_count), 1);
        checkOutput("tmo_next_overrun", W'(nOverrun), 0);

        $display("[TB] simultaneous and repeated drive edges");
        doReset();
        divDelay = 2; divRes = 0;
        applyStimulus(1, 0); tick(3);
        applyStimulus(0, 0); tick(2);
        applyStimulus(1, 1); tick(3);
        checkOutput("both_phase", W'(phase), 1);
        applyStimulus(0, 0); tick(2);
        applyStimulus(0, 1); tick(6);
        opQ.push_back(mkOp(6, 10));
        ratioQ.push_back(0);
        applyStimulus(1, 0); tick(3);
        applyStimulus(0, 0); tick(2);
        applyStimulus(1, 0); tick(7);
        applyStimulus(0, 1); tick(9);
        checkOutput("restart_no_div", W'(nStart), 1);
        divRes = 5;
        opQ.push_back(mkOp(9, 7));
        ratioQ.push_back(5);
        applyStimulus(1, 0); tick(10);
        checkOutput("restart_n_start", W'(nStart), 2);
        checkOutput("restart_n_valid", W'(nValid), 2);
        checkOutput("restart_count", W'(stroke_count), 2);
        checkOutput("restart_ratio", ratio, 5);

        $display("[TB] stall");
        doReset();
        divDelay = 2; divRes = 1;
        applyStimulus(1, 0); tick(10);
        applyStimulus(0, 1); tick(90);
        checkOutput("stall_before", W'(phase), 2);
        tick(15);
        checkOutput("stall_after", W'(phase), 0);
        applyStimulus(1, 0); tick(3);
        checkOutput("stall_fresh_phase", W'(phase), 1);
        checkOutput("stall_no_div", W'(nStart), 0);
        tick(1);
        applyStimulus(0, 1); tick(6);
        opQ.push_back(mkOp(6, 4));
        ratioQ.push_back(1);
        applyStimulus(1, 0); tick(8);
        checkOutput("stall_next_n_start", W'(nStart), 1);
        checkOutput("stall_next_ratio", ratio, 1);
        checkOutput("stall_next_count", W'(stroke_count), 1);

        checkOutput("op_queue_empty", W'(opQ.size()), 0);
        checkOutput("ratio_queue_empty", W'(ratioQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
